// File: rtl/core_lsu_pkg.sv
// ============================================================================
// Module   : core_lsu_pkg
// Brief    : Shared access-type encoding, size constants and FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_lsu_pkg;

    // bit3 = store, bit2 = unsigned, [1:0] = size
    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b0100,
        LSU_LHU = 4'b0101,
        LSU_SB  = 4'b1000,
        LSU_SH  = 4'b1001,
        LSU_SW  = 4'b1010
    } lsu_op_t;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/core_lsu_align.sv
// ============================================================================
// Module   : core_lsu_align
// Brief    : Byte-lane steering for stores, misalignment check, load extract.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_lsu_align
    import core_lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic [1:0]  i_req_size,
    input  logic        i_req_store,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  lsu_op_t     i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_req_wdata;
        o_misaligned = 1'b0;
        case (i_req_size)
            LSU_SIZE_B: begin
                o_be    = 4'b0001 << i_req_off;
                o_wdata = {4{i_req_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                o_be         = 4'b0011 << i_req_off;
                o_wdata      = {2{i_req_wdata[15:0]}};
                o_misaligned = CHECK_ALIGN && i_req_off[0];
            end
            default: begin
                o_misaligned = CHECK_ALIGN && (i_req_off != 2'b00);
            end
        endcase
        if (!i_req_store) begin
            o_wdata = 32'h0;
        end
    end

    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_op[1:0])
            LSU_SIZE_B: o_ld_data = {{24{w_shifted[7] & ~i_ld_op[2]}}, w_shifted[7:0]};
            LSU_SIZE_H: o_ld_data = {{16{w_shifted[15] & ~i_ld_op[2]}}, w_shifted[15:0]};
            default:    o_ld_data = w_shifted;
        endcase
        // Stores report zero data on completion.
        if (i_ld_op[3]) begin
            o_ld_data = 32'h0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_lsu.sv
// ============================================================================
// Module   : core_lsu
// Brief    : Single-outstanding load/store unit on a req/gnt/rvalid bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  lsu_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    lsu_op_t           r_op;
    logic [1:0]        r_off;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_mis;

    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misaligned;
    logic [31:0]       w_ld_data;

    core_lsu_align #(
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_align (
        .i_req_size   (req_op[1:0]),
        .i_req_store  (req_op[3]),
        .i_req_off    (req_addr[1:0]),
        .i_req_wdata  (req_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .i_ld_op      (r_op),
        .i_ld_off     (r_off),
        .i_rdata      (mem_rdata),
        .o_ld_data    (w_ld_data)
    );

    // A flush coincident with a request means the request is already stale.
    assign w_accept = (r_state == ST_IDLE) && req_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_misaligned) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // A granted load must still have its rvalid absorbed.
                if (mem_gnt) begin
                    if (r_op[3]) begin
                        w_state_nxt = ST_IDLE;
                    end else if (flush) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= LSU_LB;
            r_off        <= 2'b00;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_mis   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_mis   <= 1'b0;
            if (w_accept) begin
                if (w_misaligned) begin
                    r_resp_valid <= 1'b1;
                    r_resp_mis   <= 1'b1;
                    r_resp_rdata <= 32'h0;
                end else begin
                    r_op        <= req_op;
                    r_off       <= req_addr[1:0];
                    r_mem_we    <= req_op[3];
                    r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                end
            end
            if ((r_state == ST_REQ) && mem_gnt && r_op[3] && !flush) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_ld_data;
            end
            if ((r_state == ST_WAIT) && mem_rvalid && !flush) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_ld_data;
            end
        end
    end

    assign req_ready       = (r_state == ST_IDLE);
    assign busy            = (req_valid && !req_ready) || (r_state != ST_IDLE);
    assign mem_req         = (r_state == ST_REQ);
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_be          = r_mem_be;
    assign mem_wdata       = r_mem_wdata;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_resp_mis;

endmodule

`default_nettype wire

// File: tb/tb_core_lsu.sv
// ============================================================================
// Module   : tb_core_lsu
// Brief    : Directed self-checking bench for core_lsu.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_lsu;
    import core_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    lsu_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_lsu #(
        .ADDR_W      (32),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .flush           (flush),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .busy            (busy),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input string tag, input lsu_op_t op, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input lsu_op_t op, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        issue(tag, op, addr, 32'h0);
        chk({tag, "_mreq"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_wait_mreq"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_wait_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_wait_resp"}, {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, exp_data);
        chk({tag, "_mis"}, {31'b0, resp_misaligned}, 32'd0);
        tick();
        chk({tag, "_rv_end"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic do_store(input string tag, input lsu_op_t op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input int gnt_delay);
        issue(tag, op, addr, wd);
        for (int i = 0; i <= gnt_delay; i++) begin
            chk({tag, "_mreq"}, {31'b0, mem_req}, 32'd1);
            chk({tag, "_we"}, {31'b0, mem_we}, 32'd1);
            chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
            chk({tag, "_early_rv"}, {31'b0, resp_valid}, 32'd0);
            if (i == gnt_delay) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_done_mreq"}, {31'b0, mem_req}, 32'd0);
        tick();
        chk({tag, "_rv_end"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input lsu_op_t op, input logic [31:0] addr);
        issue(tag, op, addr, 32'h5A5A5A5A);
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_mis"}, {31'b0, resp_misaligned}, 32'd1);
        chk({tag, "_mreq"}, {31'b0, mem_req}, 32'd0);
        tick();
        chk({tag, "_rv_end"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_mreq_end"}, {31'b0, mem_req}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mreq"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_mis"}, {31'b0, resp_misaligned}, 32'd0);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = LSU_LW;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        chk_reset_outputs("reset");
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        do_load("lw",  LSU_LW,  32'h0000_1000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        do_load("lb",  LSU_LB,  32'h0000_1003, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
        do_load("lbu", LSU_LBU, 32'h0000_1003, 32'h80FFFFFF, 4'b1000, 32'h00000080);
        do_load("lh",  LSU_LH,  32'h0000_1002, 32'h80FFFFFF, 4'b1100, 32'hFFFF80FF);
        do_load("lhu", LSU_LHU, 32'h0000_1002, 32'h80FFFFFF, 4'b1100, 32'h000080FF);
        do_load("lb0", LSU_LB,  32'h0000_1004, 32'h1234567F, 4'b0001, 32'h0000007F);

        do_store("sh", LSU_SH, 32'h0000_2002, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 3);
        do_store("sb", LSU_SB, 32'h0000_2001, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 0);
        do_store("sw", LSU_SW, 32'h0000_2004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1);

        do_misaligned("mis_lw", LSU_LW, 32'h0000_3001);
        do_misaligned("mis_sh", LSU_SH, 32'h0000_3003);

        // Flush while waiting for read data: the late rvalid must be swallowed.
        issue("fl_wait", LSU_LW, 32'h0000_1000, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl_wait_ready", {31'b0, req_ready}, 32'd0);
            chk("fl_wait_rv", {31'b0, resp_valid}, 32'd0);
            chk("fl_wait_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        chk("fl_wait_ready_rv", {31'b0, req_ready}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("fl_wait_norsp", {31'b0, resp_valid}, 32'd0);
        chk("fl_wait_ready_after", {31'b0, req_ready}, 32'd1);
        tick();
        chk("fl_wait_norsp2", {31'b0, resp_valid}, 32'd0);
        do_load("post_fl", LSU_LW, 32'h0000_1008, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);

        // Flush while the request is still waiting for a grant.
        issue("fl_req", LSU_LW, 32'h0000_4000, 32'h0);
        chk("fl_req_mreq", {31'b0, mem_req}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_mreq_off", {31'b0, mem_req}, 32'd0);
        chk("fl_req_ready", {31'b0, req_ready}, 32'd1);
        chk("fl_req_rv", {31'b0, resp_valid}, 32'd0);
        tick();
        chk("fl_req_rv2", {31'b0, resp_valid}, 32'd0);

        // A request presented together with flush is not taken.
        req_valid = 1'b1;
        req_op    = LSU_LW;
        req_addr  = 32'h0000_5000;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("fl_idle_mreq", {31'b0, mem_req}, 32'd0);
        chk("fl_idle_rv", {31'b0, resp_valid}, 32'd0);

        // Reset in the middle of a store request.
        do_load("pre_rst", LSU_LW, 32'h0000_1000, 32'h13579BDF, 4'b1111, 32'h13579BDF);
        issue("rst_req", LSU_SW, 32'h0000_2004, 32'hCAFEF00D);
        chk("rst_req_mreq", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_mid");

        // Stale rvalid in IDLE produces nothing.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("stale_rv", {31'b0, resp_valid}, 32'd0);
        chk("stale_ready", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
